// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD-line endpoint: receives 48-bit host commands, checks them, and
// answers with an R1/R2/R3 frame after a programmable NCR gap.
module sd_card_cmd_responder #(
  parameter int unsigned NCR = 2
) (
  input  logic         sd_clk_i,
  input  logic         sys_rst_ni,
  input  logic         sd_cmd_in_i,
  output logic         sd_cmd_out_o,
  output logic         sd_cmd_en_o,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  output logic         crc_err_o,
  input  logic [1:0]   rsp_type_i,
  input  logic [31:0]  rsp_status_i,
  input  logic [119:0] rsp_long_i,
  output logic         busy_o
);

  typedef enum logic [2:0] {StIdle, StRx, StCheck, StWait, StTx} state_e;

  // Initial value is zero, so leading zero padding leaves the CRC unchanged.
  function automatic logic [6:0] crc7_calc(input logic [119:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 119; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  state_e         state_q, state_d;
  logic [46:0]    rx_shift_q, rx_shift_d;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic [5:0]     ncr_cnt_q, ncr_cnt_d;
  logic [135:0]   tx_shift_q, tx_shift_d;
  logic           tx_long_q, tx_long_d;
  logic           cmd_out_q, cmd_out_d;
  logic           cmd_en_q, cmd_en_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [5:0]     index_q, index_d;
  logic [31:0]    arg_q, arg_d;

  // The live input completes the frame on the edge that samples the end bit.
  logic [47:0]    rx_frame;
  logic [6:0]     rx_crc, r1_crc, r2_crc;
  logic           frame_ok;

  always_comb begin
    rx_frame = {rx_shift_q, sd_cmd_in_i};
    rx_crc   = crc7_calc({80'd0, rx_frame[47:8]});
    r1_crc   = crc7_calc({80'd0, 2'b00, index_q, rsp_status_i});
    r2_crc   = crc7_calc(rsp_long_i);
    frame_ok = rx_frame[46] & rx_frame[0] & (rx_frame[7:1] == rx_crc);
  end

  always_comb begin
    state_d    = state_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    ncr_cnt_d  = ncr_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_long_d  = tx_long_q;
    cmd_out_d  = cmd_out_q;
    cmd_en_d   = cmd_en_q;
    index_d    = index_q;
    arg_d      = arg_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (!sd_cmd_in_i) begin
          rx_shift_d = '0;
          bit_cnt_d  = 8'd46;
          state_d    = StRx;
        end
      end
      StRx: begin
        rx_shift_d = rx_frame[46:0];
        if (bit_cnt_q == 8'd0) begin
          state_d = StCheck;
          if (frame_ok) begin
            valid_d = 1'b1;
            index_d = rx_frame[45:40];
            arg_d   = rx_frame[39:8];
          end else begin
            err_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 8'd1;
        end
      end
      StCheck: begin
        if (valid_q && (rsp_type_i != 2'b00)) begin
          state_d   = StWait;
          ncr_cnt_d = 6'(NCR - 2);
          tx_long_d = (rsp_type_i == 2'b10);
          // Short frames are left-aligned so the MSB always leaves from bit 135.
          case (rsp_type_i)
            2'b01:   tx_shift_d = {2'b00, index_q, rsp_status_i, r1_crc, 1'b1, 88'd0};
            2'b10:   tx_shift_d = {2'b00, 6'h3F, rsp_long_i, r2_crc, 1'b1};
            default: tx_shift_d = {2'b00, 6'h3F, rsp_status_i, 7'h7F, 1'b1, 88'd0};
          endcase
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (ncr_cnt_q == 6'd0) begin
          state_d    = StTx;
          cmd_en_d   = 1'b1;
          cmd_out_d  = tx_shift_q[135];
          tx_shift_d = {tx_shift_q[134:0], 1'b0};
          bit_cnt_d  = tx_long_q ? 8'd135 : 8'd47;
        end else begin
          ncr_cnt_d = ncr_cnt_q - 6'd1;
        end
      end
      StTx: begin
        if (bit_cnt_q == 8'd0) begin
          state_d   = StIdle;
          cmd_en_d  = 1'b0;
          cmd_out_d = 1'b1;
        end else begin
          cmd_out_d  = tx_shift_q[135];
          tx_shift_d = {tx_shift_q[134:0], 1'b0};
          bit_cnt_d  = bit_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sd_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state_q    <= StIdle;
      rx_shift_q <= '0;
      bit_cnt_q  <= '0;
      ncr_cnt_q  <= '0;
      tx_shift_q <= '0;
      tx_long_q  <= 1'b0;
      cmd_out_q  <= 1'b1;
      cmd_en_q   <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      index_q    <= '0;
      arg_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      ncr_cnt_q  <= ncr_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_long_q  <= tx_long_d;
      cmd_out_q  <= cmd_out_d;
      cmd_en_q   <= cmd_en_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      index_q    <= index_d;
      arg_q      <= arg_d;
    end
  end

  assign sd_cmd_out_o = cmd_out_q;
  assign sd_cmd_en_o  = cmd_en_q;
  assign cmd_valid_o  = valid_q;
  assign crc_err_o    = err_q;
  assign cmd_index_o  = index_q;
  assign cmd_arg_o    = arg_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench for sd_card_cmd_responder: two instances (NCR=2 and NCR=8) share the
// CMD input; expected commands and responses are queued when driven, checked on output.
module tb_sd_card_cmd_responder;

  typedef struct {
    logic        err;
    logic [5:0]  idx;
    logic [31:0] arg;
  } cmd_exp_t;

  typedef struct {
    logic [135:0] bits;
    int           len;
  } rsp_exp_t;

  logic         clk;
  logic         rst_n;
  logic         cmd_in;
  logic [1:0]   rsp_type;
  logic [31:0]  rsp_status;
  logic [119:0] rsp_long;

  logic [1:0]   cmd_out, cmd_en, valid, err, busy;
  logic [5:0]   idx_o [2];
  logic [31:0]  arg_o [2];

  sd_card_cmd_responder #(.NCR(2)) u_dut_a (
    .sd_clk_i    (clk),
    .sys_rst_ni  (rst_n),
    .sd_cmd_in_i (cmd_in),
    .sd_cmd_out_o(cmd_out[0]),
    .sd_cmd_en_o (cmd_en[0]),
    .cmd_valid_o (valid[0]),
    .cmd_index_o (idx_o[0]),
    .cmd_arg_o   (arg_o[0]),
    .crc_err_o   (err[0]),
    .rsp_type_i  (rsp_type),
    .rsp_status_i(rsp_status),
    .rsp_long_i  (rsp_long),
    .busy_o      (busy[0])
  );

  sd_card_cmd_responder #(.NCR(8)) u_dut_b (
    .sd_clk_i    (clk),
    .sys_rst_ni  (rst_n),
    .sd_cmd_in_i (cmd_in),
    .sd_cmd_out_o(cmd_out[1]),
    .sd_cmd_en_o (cmd_en[1]),
    .cmd_valid_o (valid[1]),
    .cmd_index_o (idx_o[1]),
    .cmd_arg_o   (arg_o[1]),
    .crc_err_o   (err[1]),
    .rsp_type_i  (rsp_type),
    .rsp_status_i(rsp_status),
    .rsp_long_i  (rsp_long),
    .busy_o      (busy[1])
  );

  int checks;
  int failures;
  int cyc;

  cmd_exp_t exp_cmd_q [$];
  rsp_exp_t exp_rsp0_q [$];
  rsp_exp_t exp_rsp1_q [$];

  logic [1:0]   active;
  logic [135:0] col [2];
  int           col_len [2];
  int           e_cyc [2];
  int           ncr_of [2];
  logic [5:0]   last_idx;
  logic [31:0]  last_arg;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7_model(input logic [119:0] d, input int n);
    logic [6:0] c;
    logic       msb;
    c = 7'd0;
    for (int i = n - 1; i >= 0; i--) begin
      msb = c[6];
      c   = c << 1;
      if (msb ^ d[i]) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_model({80'd0, h}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] r2_bits(input logic [119:0] lng);
    return {8'h3F, lng, crc7_model(lng, 120), 1'b1};
  endfunction

  task automatic mon_step(input int i);
    cmd_exp_t c;
    rsp_exp_t r;
    if (valid[i]) begin
      e_cyc[i] = cyc;
      if (i == 0) begin
        check_eq("cmd_pending", 136'(exp_cmd_q.size() > 0), 136'd1);
        if (exp_cmd_q.size() > 0) begin
          c = exp_cmd_q.pop_front();
          check_eq("cmd_kind_valid", 136'(c.err), 136'd0);
          check_eq("cmd_index", 136'(idx_o[0]), 136'(c.idx));
          check_eq("cmd_arg", 136'(arg_o[0]), 136'(c.arg));
          last_idx = c.idx;
          last_arg = c.arg;
        end
      end
    end
    if (err[i] && (i == 0)) begin
      check_eq("err_pending", 136'(exp_cmd_q.size() > 0), 136'd1);
      if (exp_cmd_q.size() > 0) begin
        c = exp_cmd_q.pop_front();
        check_eq("cmd_kind_err", 136'(c.err), 136'd1);
        check_eq("idx_held", 136'(idx_o[0]), 136'(last_idx));
        check_eq("arg_held", 136'(arg_o[0]), 136'(last_arg));
      end
    end
    if (cmd_en[i]) begin
      if (!active[i]) begin
        active[i]  = 1'b1;
        col[i]     = '0;
        col_len[i] = 0;
        check_eq($sformatf("rsp_gap%0d", i), 136'(cyc - e_cyc[i]), 136'(ncr_of[i]));
      end
      col[i] = {col[i][134:0], cmd_out[i]};
      col_len[i]++;
    end else if (active[i]) begin
      active[i] = 1'b0;
      if (i == 0) begin
        check_eq("rsp_pending0", 136'(exp_rsp0_q.size() > 0), 136'd1);
        if (exp_rsp0_q.size() > 0) r = exp_rsp0_q.pop_front();
      end else begin
        check_eq("rsp_pending1", 136'(exp_rsp1_q.size() > 0), 136'd1);
        if (exp_rsp1_q.size() > 0) r = exp_rsp1_q.pop_front();
      end
      check_eq($sformatf("rsp_len%0d", i), 136'(col_len[i]), 136'(r.len));
      check_eq($sformatf("rsp_bits%0d", i), col[i], r.bits);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_step(0);
      mon_step(1);
    end
  end

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      cmd_in = f[i];
    end
    @(negedge clk);
    cmd_in = 1'b1;
  endtask

  task automatic wait_idle();
    int k;
    repeat (3) @(negedge clk);
    k = 0;
    while ((busy != 2'b00) && (k < 500)) begin
      @(negedge clk);
      k++;
    end
    check_eq("idle_timeout", 136'(busy), 136'd0);
    @(negedge clk);
  endtask

  task automatic expect_cmd(input logic [47:0] f, input logic good, input logic [1:0] rtype,
                            input logic [135:0] rbits, input int rlen);
    cmd_exp_t c;
    rsp_exp_t r;
    c.err = !good;
    c.idx = f[45:40];
    c.arg = f[39:8];
    exp_cmd_q.push_back(c);
    if (good && (rtype != 2'b00)) begin
      r.bits = rbits;
      r.len  = rlen;
      exp_rsp0_q.push_back(r);
      exp_rsp1_q.push_back(r);
    end
  endtask

  task automatic run_cmd(input logic [47:0] f, input logic good, input logic [1:0] rtype,
                         input logic [31:0] status, input logic [119:0] lng,
                         input logic [135:0] rbits, input int rlen);
    rsp_type   = rtype;
    rsp_status = status;
    rsp_long   = lng;
    expect_cmd(f, good, rtype, rbits, rlen);
    send_frame(f);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [119:0] lng;
    int           k;
    checks     = 0;
    failures   = 0;
    active     = 2'b00;
    ncr_of[0]  = 2;
    ncr_of[1]  = 8;
    e_cyc[0]   = 0;
    e_cyc[1]   = 0;
    last_idx   = '0;
    last_arg   = '0;
    cmd_in     = 1'b1;
    rsp_type   = 2'b00;
    rsp_status = '0;
    rsp_long   = '0;
    lng        = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #1;
    check_eq("rst_cmd_out", 136'(cmd_out), 136'h3);
    check_eq("rst_cmd_en", 136'(cmd_en), 136'h0);
    check_eq("rst_valid", 136'(valid), 136'h0);
    check_eq("rst_err", 136'(err), 136'h0);
    check_eq("rst_busy", 136'(busy), 136'h0);
    check_eq("rst_index", 136'(idx_o[0]), 136'h0);
    check_eq("rst_arg", 136'(arg_o[0]), 136'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // CMD0, no response
    run_cmd(48'h40_0000_0000_95, 1'b1, 2'b00, 32'h0, 120'h0, 136'h0, 0);
    // CMD8, R7
    run_cmd(48'h48_0000_01AA_87, 1'b1, 2'b01, 32'h0000_01AA, 120'h0,
            136'h08_0000_01AA_13, 48);
    // CMD8 with corrupted CRC, then a good CMD0
    run_cmd(48'h48_0000_01AA_85, 1'b0, 2'b01, 32'h0000_01AA, 120'h0, 136'h0, 0);
    run_cmd(48'h40_0000_0000_95, 1'b1, 2'b00, 32'h0, 120'h0, 136'h0, 0);
    // ACMD41, R3
    run_cmd(make_cmd(6'd41, 32'h40FF_8000), 1'b1, 2'b11, 32'h80FF_8000, 120'h0,
            136'h3F_80FF_8000_FF, 48);
    // CMD2, R2
    run_cmd(make_cmd(6'd2, 32'h0), 1'b1, 2'b10, 32'h0, lng, r2_bits(lng), 136);
    run_cmd(make_cmd(6'd2, 32'h0), 1'b1, 2'b10, 32'h0, ~lng, r2_bits(~lng), 136);

    // Reset in the middle of an R2 response
    rsp_type = 2'b10;
    rsp_long = lng;
    expect_cmd(make_cmd(6'd2, 32'h0), 1'b1, 2'b10, r2_bits(lng), 136);
    send_frame(make_cmd(6'd2, 32'h0));
    k = 0;
    while (!cmd_en[0] && (k < 100)) begin
      @(negedge clk);
      k++;
    end
    check_eq("r2_started", 136'(cmd_en[0]), 136'd1);
    repeat (40) @(negedge clk);
    check_eq("busy_mid_r2", 136'(busy), 136'h3);
    #2;
    rst_n  = 1'b0;
    active = 2'b00;
    exp_rsp0_q.delete();
    exp_rsp1_q.delete();
    #1;
    check_eq("abort_cmd_en", 136'(cmd_en), 136'h0);
    check_eq("abort_cmd_out", 136'(cmd_out), 136'h3);
    check_eq("abort_busy", 136'(busy), 136'h0);
    check_eq("abort_index", 136'(idx_o[0]), 136'h0);
    last_idx = '0;
    last_arg = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_cmd(48'h40_0000_0000_95, 1'b1, 2'b00, 32'h0, 120'h0, 136'h0, 0);

    repeat (5) @(negedge clk);
    check_eq("cmd_q_empty", 136'(exp_cmd_q.size()), 136'd0);
    check_eq("rsp0_q_empty", 136'(exp_rsp0_q.size()), 136'd0);
    check_eq("rsp1_q_empty", 136'(exp_rsp1_q.size()), 136'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
